mem_access_ctrl: RTL

Initiator side of the data-memory interface. Accepts one load or store request at a time from the datapath over a valid/ready handshake. Drives the memory's mem_read/mem_write strobes, address (r_a) and write data (r_b) for the required number of cycles, captures data_out, and returns a one-cycle response pulse. It sits between the execute stage and the data memory, so the datapath never sequences memory strobes itself.

---
 rtl/mem_access_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// Data-memory initiator: one load/store at a time over valid/ready,
// sequences mem_read/mem_write and returns a one-cycle response pulse.
module mem_access_ctrl #(
   parameter int MEM_LATENCY = 1,
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_is_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic              resp_is_write,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              is_wr_q, is_wr_d;
   logic              accept;

   assign req_ready = (state_q == IDLE) || (state_q == RESP);
   assign accept    = req_valid && req_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         is_wr_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         is_wr_q <= is_wr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      is_wr_d = is_wr_q;
      unique case (state_q)
         IDLE, RESP: begin
            state_d = IDLE;
            if (accept) begin
               addr_d  = req_addr;
               is_wr_d = req_is_write;
               cnt_d   = LAT_M1;
               if (req_is_write) begin
                  wdata_d = req_wdata;
                  state_d = WRITE;
               end else begin
                  state_d = READ;
               end
            end
         end
         READ: begin
            // Sample memory on the edge closing the last held cycle
            if (cnt_q == 4'd0) begin
               rdata_d = mem_rdata;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         WRITE: begin
            state_d = RESP;
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem_read      = (state_q == READ);
   assign mem_write     = (state_q == WRITE);
   assign mem_addr      = addr_q;
   assign mem_wdata     = wdata_q;
   assign resp_valid    = (state_q == RESP);
   assign resp_is_write = is_wr_q;
   assign resp_rdata    = rdata_q;
   assign busy          = (state_q != IDLE);

endmodule
